baw_game_core: RTL and testbench

Parametrised black-and-white card game engine. Two players each hold NUM_CARDS cards valued 0..NUM_CARDS-1; odd values are black, even values are white. Each round both players commit one unused card; the higher card wins the round. The block tracks hands, scores and game termination, and exposes counts and results to the display and LED layers of the board top level.

---
 rtl/baw_pkg.sv | 25 ++
 rtl/baw_onehot_check.sv | 26 ++
 rtl/baw_game_core.sv | 203 ++++++++++++++++++++
 tb/tb_baw_game_core.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/baw_pkg.sv
// rtl/baw_pkg.sv - shared types, result codes and width helper for the card game engine
// Contents:
//   state_e    FSM state encoding exported on the `state` port
//   RES_*      round/game result codes (none, P1, P2, tie)
//   calc_cw    counter width able to hold 0..n
package baw_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FIRST  = 3'd1,
        ST_SECOND = 3'd2,
        ST_REVEAL = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_P1   = 2'b01;
    localparam logic [1:0] RES_P2   = 2'b10;
    localparam logic [1:0] RES_TIE  = 2'b11;

    function automatic int calc_cw(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/baw_onehot_check.sv
// rtl/baw_onehot_check.sv - validates a one-hot card selection against a hand
// Ports:
//   sel    card selection (must be exactly one bit set)
//   hand   unused-card mask of the player about to play
//   valid  selection is one-hot and the card is still in the hand
//   idx    binary index of the selected card (meaningful only when valid)
module baw_onehot_check #(
    parameter int N  = 9,
    parameter int IW = 4
) (
    input  logic [N-1:0]  sel,
    input  logic [N-1:0]  hand,
    output logic          valid,
    output logic [IW-1:0] idx
);

    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (sel[i]) idx = IW'(i);
        end
        // x & (x-1) clears the lowest set bit, so zero means at most one bit set
        valid = (sel != '0) && ((sel & (sel - N'(1))) == '0) && ((sel & hand) != '0);
    end

endmodule

// File: rtl/baw_game_core.sv
// rtl/baw_game_core.sv - two-player black-and-white card game engine
// Build option: BAW_EDGE_DETECT_EN - buttons pass through a registered rising-edge
//   detector (held buttons act once, one extra cycle of latency).
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   btn_start/play/next/abort    game buttons (abort > start > play > next)
//   card_sel                     one-hot card choice for the active player
//   state, active_player, round  FSM state, who plays next, completed rounds
//   p1_wins, p2_wins             round wins
//   p1_hand, p2_hand             unused-card masks
//   p1/p2_black, p1/p2_white     combinational popcounts of odd/even unused cards
//   p1/p2_last_black             colour of each player's card this round
//   match_result, game_result    last round / final game result codes
//   finish, sel_error            game over, one-cycle rejected-play pulse
module baw_game_core
    import baw_pkg::*;
#(
    parameter int  NUM_CARDS  = 9,
    parameter int  WIN_TARGET = 5,
    localparam int CW         = calc_cw(NUM_CARDS)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 btn_start,
    input  logic                 btn_play,
    input  logic                 btn_next,
    input  logic                 btn_abort,
    input  logic [NUM_CARDS-1:0] card_sel,
    output logic [2:0]           state,
    output logic                 active_player,
    output logic [CW-1:0]        round,
    output logic [CW-1:0]        p1_wins,
    output logic [CW-1:0]        p2_wins,
    output logic [NUM_CARDS-1:0] p1_hand,
    output logic [NUM_CARDS-1:0] p2_hand,
    output logic [CW-1:0]        p1_black,
    output logic [CW-1:0]        p1_white,
    output logic [CW-1:0]        p2_black,
    output logic [CW-1:0]        p2_white,
    output logic                 p1_last_black,
    output logic                 p2_last_black,
    output logic [1:0]           match_result,
    output logic [1:0]           game_result,
    output logic                 finish,
    output logic                 sel_error
);

    localparam int IW = (NUM_CARDS > 1) ? $clog2(NUM_CARDS) : 1;
    localparam logic [CW-1:0] WIN_T  = CW'(WIN_TARGET);
    localparam logic [CW-1:0] ROUNDS = CW'(NUM_CARDS);

    logic                 go_abort, go_start, go_play, go_next;
    logic [NUM_CARDS-1:0] sel;

`ifdef BAW_EDGE_DETECT_EN
    logic [3:0]           btn_prev_q, btn_edge_q;
    logic [NUM_CARDS-1:0] sel_q;

    // card_sel is delayed alongside the buttons so the pair stays aligned
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            btn_prev_q <= '0;
            btn_edge_q <= '0;
            sel_q      <= '0;
        end else begin
            btn_prev_q <= {btn_abort, btn_start, btn_play, btn_next};
            btn_edge_q <= {btn_abort, btn_start, btn_play, btn_next} & ~btn_prev_q;
            sel_q      <= card_sel;
        end
    end

    assign {go_abort, go_start, go_play, go_next} = btn_edge_q;
    assign sel = sel_q;
`else
    assign {go_abort, go_start, go_play, go_next} = {btn_abort, btn_start, btn_play, btn_next};
    assign sel = card_sel;
`endif

    state_e               state_q;
    logic [IW-1:0]        p1_card_q, p2_card_q;
    logic [NUM_CARDS-1:0] hand_act;
    logic                 sel_valid;
    logic [IW-1:0]        sel_idx;
    logic [IW-1:0]        p1_c, p2_c;

    assign state    = state_q;
    assign hand_act = active_player ? p2_hand : p1_hand;

    baw_onehot_check #(.N(NUM_CARDS), .IW(IW)) u_check (
        .sel   (sel),
        .hand  (hand_act),
        .valid (sel_valid),
        .idx   (sel_idx)
    );

    // Cards as they stand once the second mover commits this cycle
    assign p1_c = active_player ? p1_card_q : sel_idx;
    assign p2_c = active_player ? sel_idx : p2_card_q;

    always_comb begin
        p1_black = '0;
        p1_white = '0;
        p2_black = '0;
        p2_white = '0;
        for (int i = 0; i < NUM_CARDS; i++) begin
            if (i % 2 == 1) begin
                p1_black = p1_black + CW'(p1_hand[i]);
                p2_black = p2_black + CW'(p2_hand[i]);
            end else begin
                p1_white = p1_white + CW'(p1_hand[i]);
                p2_white = p2_white + CW'(p2_hand[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || go_abort) begin
            state_q       <= ST_IDLE;
            active_player <= 1'b0;
            round         <= '0;
            p1_wins       <= '0;
            p2_wins       <= '0;
            p1_hand       <= '0;
            p2_hand       <= '0;
            p1_card_q     <= '0;
            p2_card_q     <= '0;
            p1_last_black <= 1'b0;
            p2_last_black <= 1'b0;
            match_result  <= RES_NONE;
            game_result   <= RES_NONE;
            finish        <= 1'b0;
            sel_error     <= 1'b0;
        end else begin
            sel_error <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (go_start) begin
                        state_q       <= ST_FIRST;
                        active_player <= 1'b0;
                        round         <= '0;
                        p1_wins       <= '0;
                        p2_wins       <= '0;
                        p1_hand       <= '1;
                        p2_hand       <= '1;
                        match_result  <= RES_NONE;
                        game_result   <= RES_NONE;
                        finish        <= 1'b0;
                    end
                end
                ST_FIRST, ST_SECOND: begin
                    if (go_play) begin
                        if (!sel_valid) begin
                            sel_error <= 1'b1;
                        end else begin
                            if (active_player) begin
                                p2_hand       <= p2_hand & ~sel;
                                p2_card_q     <= sel_idx;
                                p2_last_black <= sel_idx[0];
                            end else begin
                                p1_hand       <= p1_hand & ~sel;
                                p1_card_q     <= sel_idx;
                                p1_last_black <= sel_idx[0];
                            end
                            if (state_q == ST_FIRST) begin
                                state_q       <= ST_SECOND;
                                active_player <= ~active_player;
                            end else begin
                                state_q <= ST_REVEAL;
                                round   <= round + CW'(1);
                                if (p1_c > p2_c) begin
                                    p1_wins      <= p1_wins + CW'(1);
                                    match_result <= RES_P1;
                                end else if (p2_c > p1_c) begin
                                    p2_wins      <= p2_wins + CW'(1);
                                    match_result <= RES_P2;
                                end else begin
                                    match_result <= RES_TIE;
                                end
                            end
                        end
                    end
                end
                ST_REVEAL: begin
                    if (go_next) begin
                        if (p1_wins == WIN_T || p2_wins == WIN_T || round == ROUNDS) begin
                            state_q <= ST_DONE;
                            finish  <= 1'b1;
                            if (p1_wins > p2_wins)      game_result <= RES_P1;
                            else if (p2_wins > p1_wins) game_result <= RES_P2;
                            else                        game_result <= RES_TIE;
                        end else begin
                            state_q       <= ST_FIRST;
                            // P1 leads even rounds, P2 leads odd rounds
                            active_player <= round[0];
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_baw_game_core.sv
// tb/tb_baw_game_core.sv - self-checking bench for baw_game_core with a behavioural game model
module tb_baw_game_core;
    import baw_pkg::*;

    localparam int NUM = 9;
    localparam int WIN = 5;
    localparam int CW  = $clog2(NUM + 1);
`ifdef BAW_EDGE_DETECT_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           btn_start = 1'b0, btn_play = 1'b0, btn_next = 1'b0, btn_abort = 1'b0;
    logic [NUM-1:0] card_sel = '0;
    logic [2:0]     state;
    logic           active_player;
    logic [CW-1:0]  round, p1_wins, p2_wins;
    logic [NUM-1:0] p1_hand, p2_hand;
    logic [CW-1:0]  p1_black, p1_white, p2_black, p2_white;
    logic           p1_last_black, p2_last_black;
    logic [1:0]     match_result, game_result;
    logic           finish, sel_error;

    baw_game_core #(.NUM_CARDS(NUM), .WIN_TARGET(WIN)) dut (
        .clk(clk), .reset_n(reset_n),
        .btn_start(btn_start), .btn_play(btn_play), .btn_next(btn_next), .btn_abort(btn_abort),
        .card_sel(card_sel), .state(state), .active_player(active_player), .round(round),
        .p1_wins(p1_wins), .p2_wins(p2_wins), .p1_hand(p1_hand), .p2_hand(p2_hand),
        .p1_black(p1_black), .p1_white(p1_white), .p2_black(p2_black), .p2_white(p2_white),
        .p1_last_black(p1_last_black), .p2_last_black(p2_last_black),
        .match_result(match_result), .game_result(game_result),
        .finish(finish), .sel_error(sel_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int  m_state;
    bit  m_act;
    int  m_round;
    int  m_win [2];
    int  m_card [2];
    bit  m_lb [2];
    bit  m_loaded;
    bit  m_used [2][NUM];
    int  m_match, m_game;
    bit  m_fin, m_serr;
`ifdef BAW_EDGE_DETECT_EN
    bit  e_a, e_s, e_p, e_n, pv_a, pv_s, pv_p, pv_n;
    int  e_sel;
`endif

    function automatic int hand_of(input int pl);
        int m = 0;
        for (int i = 0; i < NUM; i++)
            if (m_loaded && !m_used[pl][i]) m += (1 << i);
        return m;
    endfunction

    function automatic int colour_count(input int pl, input int odd);
        int c = 0;
        for (int i = 0; i < NUM; i++)
            if (m_loaded && !m_used[pl][i] && (i % 2 == odd)) c++;
        return c;
    endfunction

    task automatic model_step();
        bit a, s, p, n;
        int sel, c;
`ifdef BAW_EDGE_DETECT_EN
        a = e_a; s = e_s; p = e_p; n = e_n; sel = e_sel;
        if (!reset_n) begin
            e_a = 0; e_s = 0; e_p = 0; e_n = 0; pv_a = 0; pv_s = 0; pv_p = 0; pv_n = 0; e_sel = 0;
        end else begin
            e_a = btn_abort && !pv_a; e_s = btn_start && !pv_s;
            e_p = btn_play && !pv_p;  e_n = btn_next && !pv_n;
            pv_a = btn_abort; pv_s = btn_start; pv_p = btn_play; pv_n = btn_next;
            e_sel = int'(card_sel);
        end
`else
        a = btn_abort; s = btn_start; p = btn_play; n = btn_next; sel = int'(card_sel);
`endif
        m_serr = 0;
        if (!reset_n || a) begin
            m_state = ST_IDLE; m_act = 0; m_round = 0; m_win[0] = 0; m_win[1] = 0;
            m_loaded = 0; m_lb[0] = 0; m_lb[1] = 0; m_match = RES_NONE; m_game = RES_NONE; m_fin = 0;
            return;
        end
        if (m_state == ST_IDLE || m_state == ST_DONE) begin
            if (s) begin
                m_state = ST_FIRST; m_act = 0; m_round = 0; m_win[0] = 0; m_win[1] = 0;
                m_loaded = 1; m_match = RES_NONE; m_game = RES_NONE; m_fin = 0;
                for (int pl = 0; pl < 2; pl++)
                    for (int i = 0; i < NUM; i++) m_used[pl][i] = 0;
            end
        end else if (m_state == ST_FIRST || m_state == ST_SECOND) begin
            if (p) begin
                c = 0;
                for (int i = 0; i < NUM; i++) if (sel & (1 << i)) c = i;
                if ($countones(sel) != 1 || m_used[m_act][c]) begin
                    m_serr = 1;
                end else begin
                    m_used[m_act][c] = 1;
                    m_card[m_act] = c;
                    m_lb[m_act] = (c % 2 == 1);
                    if (m_state == ST_FIRST) begin
                        m_state = ST_SECOND;
                        m_act = !m_act;
                    end else begin
                        m_state = ST_REVEAL;
                        m_round++;
                        if (m_card[0] > m_card[1]) begin m_win[0]++; m_match = RES_P1; end
                        else if (m_card[1] > m_card[0]) begin m_win[1]++; m_match = RES_P2; end
                        else m_match = RES_TIE;
                    end
                end
            end
        end else if (m_state == ST_REVEAL) begin
            if (n) begin
                if (m_win[0] == WIN || m_win[1] == WIN || m_round == NUM) begin
                    m_state = ST_DONE; m_fin = 1;
                    m_game = (m_win[0] > m_win[1]) ? RES_P1 : (m_win[1] > m_win[0]) ? RES_P2 : RES_TIE;
                end else begin
                    m_state = ST_FIRST;
                    m_act = (m_round % 2 == 1);
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("state", state, m_state);
        chk("active_player", active_player, m_act);
        chk("round", round, m_round);
        chk("p1_wins", p1_wins, m_win[0]);
        chk("p2_wins", p2_wins, m_win[1]);
        chk("p1_hand", p1_hand, hand_of(0));
        chk("p2_hand", p2_hand, hand_of(1));
        chk("p1_black", p1_black, colour_count(0, 1));
        chk("p1_white", p1_white, colour_count(0, 0));
        chk("p2_black", p2_black, colour_count(1, 1));
        chk("p2_white", p2_white, colour_count(1, 0));
        chk("p1_last_black", p1_last_black, m_lb[0]);
        chk("p2_last_black", p2_last_black, m_lb[1]);
        chk("match_result", match_result, m_match);
        chk("game_result", game_result, m_game);
        chk("finish", finish, m_fin);
        chk("sel_error", sel_error, m_serr);
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        compare_all();
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit a, input bit s, input bit p, input bit n, input int sel);
        btn_abort = a; btn_start = s; btn_play = p; btn_next = n;
        card_sel = sel[NUM-1:0];
    endtask

    task automatic pulse(input bit a, input bit s, input bit p, input bit n, input int sel);
        drive(a, s, p, n, sel);
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
    endtask

    task automatic play(input int c);
        pulse(0, 0, 1, 0, 1 << c);
    endtask

    task automatic play_pair(input int r, input int c1, input int c2);
        if (r % 2 == 0) begin play(c1); play(c2); end
        else begin play(c2); play(c1); end
    endtask

    task automatic reject(input string name, input int sel);
        drive(0, 0, 1, 0, sel);
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        repeat (LAT) @(negedge clk);
        chk(name, sel_error, 1);
        @(negedge clk);
        chk({name, "_state"}, state, ST_FIRST);
    endtask

    initial begin
        int r, sel;
        bit a, s, p, n;
        int cand[$];

        @(negedge clk);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_state", state, ST_IDLE);
        chk("rst_p1_hand", p1_hand, 0);
        chk("rst_round", round, 0);
        chk("rst_finish", finish, 0);

        pulse(0, 1, 0, 0, 0);
        chk("start_state", state, ST_FIRST);
        chk("start_p1_hand", p1_hand, 'h1FF);
        chk("start_p2_hand", p2_hand, 'h1FF);
        chk("start_p1_black", p1_black, 4);
        chk("start_p1_white", p1_white, 5);

        play(8);
        play(3);
        chk("r0_state", state, ST_REVEAL);
        chk("r0_match", match_result, 2'b01);
        chk("r0_p1_wins", p1_wins, 1);
        chk("r0_round", round, 1);
        chk("r0_p2_last_black", p2_last_black, 1);
        pulse(0, 0, 0, 1, 0);
        chk("r1_active", active_player, 1);

        reject("rej_used", 1 << 3);
        reject("rej_zero", 0);
        reject("rej_two_hot", 'h003);
        chk("rej_p2_hand", p2_hand, 'h1F7);

        // P1 wins five straight rounds
        pulse(1, 0, 0, 0, 0);
        pulse(0, 1, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            play_pair(k, k + 4, k);
            pulse(0, 0, 0, 1, 0);
        end
        chk("win5_state", state, ST_DONE);
        chk("win5_finish", finish, 1);
        chk("win5_game", game_result, 2'b01);
        chk("win5_round", round, 5);

        // Mirrored play, every round ties, restart straight from DONE
        pulse(0, 1, 0, 0, 0);
        for (int k = 0; k < NUM; k++) begin
            play_pair(k, k, k);
            pulse(0, 0, 0, 1, 0);
        end
        chk("tie_round", round, 9);
        chk("tie_game", game_result, 2'b11);
        chk("tie_p1_hand", p1_hand, 0);
        chk("tie_state", state, ST_DONE);

        // Abort wins over a simultaneous play in SECOND
        pulse(0, 1, 0, 0, 0);
        play(7);
        pulse(1, 0, 1, 0, 1 << 2);
        chk("abort_state", state, ST_IDLE);
        chk("abort_p1_hand", p1_hand, 0);
        chk("abort_p2_hand", p2_hand, 0);
        chk("abort_p1_last_black", p1_last_black, 0);
        chk("abort_active", active_player, 0);

`ifdef BAW_EDGE_DETECT_EN
        pulse(0, 1, 0, 0, 0);
        drive(0, 0, 1, 0, 1 << 2);
        repeat (3) @(negedge clk);
        drive(0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk("hold_p1_hand", p1_hand, 'h1FB);
        chk("hold_state", state, ST_SECOND);
        chk("hold_p2_hand", p2_hand, 'h1FF);
        pulse(1, 0, 0, 0, 0);
`endif

        // Randomised play against the model
        for (int k = 0; k < 600; k++) begin
            r = $urandom_range(0, 99);
            a = 0; s = 0; p = 0; n = 0;
            if (r < 1) a = 1;
            else if (r < 6) s = 1;
            else if (r < 75) p = 1;
            else n = 1;
            if ($urandom_range(0, 24) == 0) s = 1;
            if ($urandom_range(0, 24) == 0) n = 1;
            if ($urandom_range(0, 199) == 0) a = 1;
            cand = {};
            for (int i = 0; i < NUM; i++)
                if (m_loaded && !m_used[m_act][i]) cand.push_back(i);
            if (cand.size() > 0 && $urandom_range(0, 3) != 0)
                sel = 1 << cand[$urandom_range(0, cand.size() - 1)];
            else
                sel = int'($urandom_range(0, (1 << NUM) - 1));
            reset_n = ($urandom_range(0, 299) != 0);
            drive(a, s, p, n, sel);
            @(negedge clk);
        end
        drive(0, 0, 0, 0, 0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
